// File: rtl/ssd_scan_if.sv
// Display bus between the game/score logic (master) and the seven-segment scan driver (slave).
interface ssd_scan_if #(
  parameter int NUM_DIGITS = 8
);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [4*NUM_DIGITS-1:0] value;
  logic                    load;
  logic [NUM_DIGITS-1:0]   dp_mask;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic [NUM_DIGITS-1:0]   anodes;
  logic [7:0]              cathodes;
  logic [IDX_W-1:0]        scan_idx;
  logic                    frame_tick;

  modport master (
    output value, load, dp_mask, digit_en,
    input  anodes, cathodes, scan_idx, frame_tick
  );

  modport slave (
    input  value, load, dp_mask, digit_en,
    output anodes, cathodes, scan_idx, frame_tick
  );
endinterface

// File: rtl/ssd_scan_ctrl.sv
// N-digit multiplexed seven-segment driver with frame-synchronous value update and anti-ghost blanking.
// Optional feature: define SSD_LZ_BLANK_EN for leading-zero suppression on the shown value.
module ssd_scan_ctrl #(
  parameter int NUM_DIGITS   = 8,
  parameter int SCAN_DIV     = 262144,
  parameter int BLANK_CYCLES = 1024
) (
  input logic       ClkPort,
  input logic       Reset,
  ssd_scan_if.slave bus
);
  localparam int PW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VW    = 4 * NUM_DIGITS;

  localparam logic [PW-1:0]    PRE_LAST  = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0]    BLANK_LIM = PW'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [PW-1:0]    prescaler;
  logic [IDX_W-1:0] scan_idx;
  logic [VW-1:0]    pending, shown;
  logic             slot_wrap, frame_wrap;

  assign slot_wrap  = (prescaler == PRE_LAST);
  assign frame_wrap = slot_wrap && (scan_idx == IDX_LAST);

  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      prescaler <= '0;
      scan_idx  <= '0;
    end else begin
      prescaler <= slot_wrap ? '0 : prescaler + 1'b1;
      if (slot_wrap) scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
    end
  end

  // shown only moves on the frame wrap so a frame never mixes old and new digits;
  // a load landing on that very cycle bypasses pending.
  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      pending <= '0;
      shown   <= '0;
    end else begin
      if (bus.load)  pending <= bus.value;
      if (frame_wrap) shown  <= bus.load ? bus.value : pending;
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'b0000001;  4'h1: seg7 = 7'b1001111;
      4'h2: seg7 = 7'b0010010;  4'h3: seg7 = 7'b0000110;
      4'h4: seg7 = 7'b1001100;  4'h5: seg7 = 7'b0100100;
      4'h6: seg7 = 7'b0100000;  4'h7: seg7 = 7'b0001111;
      4'h8: seg7 = 7'b0000000;  4'h9: seg7 = 7'b0000100;
      4'hA: seg7 = 7'b0001000;  4'hB: seg7 = 7'b1100000;
      4'hC: seg7 = 7'b0110001;  4'hD: seg7 = 7'b1000010;
      4'hE: seg7 = 7'b0110000;  default: seg7 = 7'b0111000;
    endcase
  endfunction

  logic lz_cur;
`ifdef SSD_LZ_BLANK_EN
  // lz[k]: nibbles k..top of shown are all zero; digit 0 always shows.
  logic [NUM_DIGITS-1:0] lz;
  assign lz[0] = 1'b0;
  for (genvar k = 1; k < NUM_DIGITS; k++) begin : g_lz
    assign lz[k] = ~|shown[VW-1:4*k];
  end
  assign lz_cur = lz[scan_idx];
`else
  assign lz_cur = 1'b0;
`endif

  logic [NUM_DIGITS-1:0] an_nxt;
  logic [7:0]            cat_nxt;
  logic [3:0]            nib;
  logic                  blank;

  always_comb begin
    nib     = shown[4*int'(scan_idx) +: 4];
    blank   = ((BLANK_CYCLES != 0) && (prescaler < BLANK_LIM)) || !bus.digit_en[scan_idx];
    an_nxt  = '1;
    cat_nxt = 8'hFF;
    if (!blank) begin
      an_nxt[scan_idx] = 1'b0;
      cat_nxt = {lz_cur ? 7'h7F : seg7(nib), ~bus.dp_mask[scan_idx]};
    end
  end

  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      bus.anodes     <= '1;
      bus.cathodes   <= 8'hFF;
      bus.frame_tick <= 1'b0;
    end else begin
      bus.anodes     <= an_nxt;
      bus.cathodes   <= cat_nxt;
      bus.frame_tick <= frame_wrap;
    end
  end

  assign bus.scan_idx = scan_idx;
endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Directed bench for ssd_scan_ctrl at NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2 (32-cycle frame).
module tb_ssd_scan_ctrl;
  logic ClkPort = 1'b0;
  logic Reset   = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 ClkPort = ~ClkPort;

  ssd_scan_if #(.NUM_DIGITS(4)) bus ();

  ssd_scan_ctrl #(.NUM_DIGITS(4), .SCAN_DIV(8), .BLANK_CYCLES(2)) dut (
    .ClkPort (ClkPort),
    .Reset   (Reset),
    .bus     (bus)
  );

  localparam logic [6:0] SEG [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_an(input logic [3:0] en, input int d, input int p);
    if (p < 2 || !en[d]) return 4'hF;
    return ~(4'(1) << d);
  endfunction

  function automatic logic [7:0] exp_cat(input logic [15:0] sv, input logic [3:0] en,
                                         input logic [3:0] dp, input int d, input int p);
    logic [6:0] seg;
    if (p < 2 || !en[d]) return 8'hFF;
    seg = SEG[sv[4*d +: 4]];
`ifdef SSD_LZ_BLANK_EN
    if (d > 0 && (sv >> (4*d)) == 16'h0) seg = 7'h7F;
`endif
    return {seg, ~dp[d]};
  endfunction

  task automatic step();
    @(posedge ClkPort);
    #1;
  endtask

  // Runs one full frame from state position 0, checking every cycle against the
  // value expected on display (sv). Optional loads are applied at positions la1/la2.
  task automatic run_frame(input logic [15:0] sv, input logic [3:0] en, input logic [3:0] dp,
                           input int la1, input logic [15:0] v1,
                           input int la2, input logic [15:0] v2);
    bus.digit_en = en;
    bus.dp_mask  = dp;
    for (int k = 1; k <= 32; k++) begin
      int s;
      s = k - 1;
      if (s == la1) begin bus.value = v1; bus.load = 1'b1; end
      if (s == la2) begin bus.value = v2; bus.load = 1'b1; end
      step();
      bus.load = 1'b0;
      chk($sformatf("anodes v%h k%0d", sv, k), 8'(bus.anodes), 8'(exp_an(en, s / 8, s % 8)));
      chk($sformatf("cathodes v%h k%0d", sv, k), bus.cathodes, exp_cat(sv, en, dp, s / 8, s % 8));
      chk($sformatf("frame_tick k%0d", k), 8'(bus.frame_tick), 8'(k == 32));
      chk($sformatf("scan_idx k%0d", k), 8'(bus.scan_idx), 8'((k % 32) / 8));
    end
  endtask

  initial begin
    bus.value    = 16'h0;
    bus.load     = 1'b0;
    bus.dp_mask  = 4'h0;
    bus.digit_en = 4'hF;

    // Reset values
    step();
    step();
    chk("rst anodes", 8'(bus.anodes), 8'h0F);
    chk("rst cathodes", bus.cathodes, 8'hFF);
    chk("rst frame_tick", 8'(bus.frame_tick), 8'h00);
    chk("rst scan_idx", 8'(bus.scan_idx), 8'h00);
    Reset = 1'b0;

    // Free run, then a mid-frame load that must wait for the next frame
    run_frame(16'h0000, 4'hF, 4'h0, -1, 16'h0, -1, 16'h0);
    run_frame(16'h0000, 4'hF, 4'h0,  3, 16'h12AF, -1, 16'h0);
    run_frame(16'h12AF, 4'hF, 4'h0,  5, 16'h5555, 20, 16'h9999);
    // 9999 overwrote 5555 in pending; a load on the wrap cycle lands immediately
    run_frame(16'h9999, 4'hF, 4'h0, 31, 16'h3C7E, -1, 16'h0);
    // Per-digit enable and decimal points
    run_frame(16'h3C7E, 4'b1010, 4'b0010, 10, 16'h0040, -1, 16'h0);
    run_frame(16'h0040, 4'hF, 4'h0, 31, 16'h0000, -1, 16'h0);
    run_frame(16'h0000, 4'hF, 4'h0,  5, 16'h8421, -1, 16'h0);

    // Reset mid-slot on digit 2 while 8421 is shown
    for (int i = 0; i < 20; i++) step();
    chk("pre-rst anodes d2", 8'(bus.anodes), 8'h0B);
    chk("pre-rst cathodes d2", bus.cathodes, 8'h99);
    chk("pre-rst scan_idx", 8'(bus.scan_idx), 8'h02);
    Reset = 1'b1;
    #1;
    chk("async rst anodes", 8'(bus.anodes), 8'h0F);
    chk("async rst cathodes", bus.cathodes, 8'hFF);
    chk("async rst scan_idx", 8'(bus.scan_idx), 8'h00);
    step();
    Reset = 1'b0;
    // pending was cleared too, so 8421 must not reappear
    run_frame(16'h0000, 4'hF, 4'h0, -1, 16'h0, -1, 16'h0);
    run_frame(16'h0000, 4'hF, 4'h0, -1, 16'h0, -1, 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
